stopwatch_display_scan: RTL

- Downstream consumer of the stopwatch BCD digit counters.
- Takes four 4-bit BCD digits and time-multiplexes them onto a common-anode 4-digit 7-segment display with active-low anodes and segments.
- Provides frame-coherent input capture, an anti-ghosting blank interval, leading-zero blanking, per-digit decimal point, and a dash for invalid codes.

---
 rtl/stopwatch_display_scan_if.sv | 26 ++
 rtl/stopwatch_display_scan.sv | 109 ++++++++++
 2 files changed

// File: rtl/stopwatch_display_scan_if.sv
// Digit/display bundle between the stopwatch counters, the scan block and the
// 7-segment display pins.
interface stopwatch_display_scan_if;
  logic [3:0] d0;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic [3:0] dp_en;
  logic       blank_lz;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] digit_sel;

  // Digit source side: supplies digits, observes the display drive.
  modport master (
    output d0, d1, d2, d3, dp_en, blank_lz,
    input  an, seg, dp, digit_sel
  );

  // Scan block side.
  modport slave (
    input  d0, d1, d2, d3, dp_en, blank_lz,
    output an, seg, dp, digit_sel
  );
endinterface

// File: rtl/stopwatch_display_scan.sv
// Time-multiplexed scan of four BCD digits onto a common-anode 4-digit
// 7-segment display (active-low anodes, segments and decimal point).
// Inputs are captured once per frame so a frame never mixes two readings.
module stopwatch_display_scan #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input logic                     clk,
  input logic                     r,
  stopwatch_display_scan_if.slave bus
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);

  logic [PW-1:0] p;
  logic [1:0]    k;
  logic [3:0]    snap_d [4];
  logic [3:0]    snap_dp;
  logic          snap_bl;

  logic          slot_end;
  logic [3:0]    cur_digit;
  logic [6:0]    cur_seg;
  logic [3:0]    lz_blank;

  assign slot_end = (p == P_LAST);

  // Prescaler and slot counter: one slot every REFRESH_DIV cycles.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      p <= '0;
      k <= '0;
    end else if (slot_end) begin
      p <= '0;
      k <= k + 2'd1;
    end else begin
      p <= p + 1'b1;
    end
  end

  // Frame snapshot: inputs sampled on the last cycle of slot 3 only.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      snap_d[0] <= '0;
      snap_d[1] <= '0;
      snap_d[2] <= '0;
      snap_d[3] <= '0;
      snap_dp   <= '0;
      snap_bl   <= 1'b0;
    end else if (slot_end && (k == 2'd3)) begin
      snap_d[0] <= bus.d0;
      snap_d[1] <= bus.d1;
      snap_d[2] <= bus.d2;
      snap_d[3] <= bus.d3;
      snap_dp   <= bus.dp_en;
      snap_bl   <= bus.blank_lz;
    end
  end

  // Leading-zero mask: a digit blanks only if it and all digits to its left
  // are zero; codes 10..15 are not zero so they stop the blanking chain.
  always_comb begin
    lz_blank    = '0;
    lz_blank[3] = snap_bl && (snap_d[3] == 4'd0);
    lz_blank[2] = lz_blank[3] && (snap_d[2] == 4'd0);
    lz_blank[1] = lz_blank[2] && (snap_d[1] == 4'd0);
  end

  // Segment decode of the current slot's digit, {g,f,e,d,c,b,a} active-low.
  always_comb begin
    cur_digit = snap_d[k];
    cur_seg   = 7'b0111111;
    case (cur_digit)
      4'd0:    cur_seg = 7'b1000000;
      4'd1:    cur_seg = 7'b1111001;
      4'd2:    cur_seg = 7'b0100100;
      4'd3:    cur_seg = 7'b0110000;
      4'd4:    cur_seg = 7'b0011001;
      4'd5:    cur_seg = 7'b0010010;
      4'd6:    cur_seg = 7'b0000010;
      4'd7:    cur_seg = 7'b1111000;
      4'd8:    cur_seg = 7'b0000000;
      4'd9:    cur_seg = 7'b0010000;
      default: cur_seg = 7'b0111111;
    endcase
    if (lz_blank[k]) begin
      cur_seg = 7'b1111111;
    end
  end

  // Registered display drive; anodes are held off for the first BLANK_CYCLES
  // of each slot while seg/dp already switch, which hides ghosting.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      bus.an        <= '1;
      bus.seg       <= '1;
      bus.dp        <= 1'b1;
      bus.digit_sel <= '0;
    end else begin
      bus.digit_sel <= k;
      bus.an        <= (p < P_BLANK) ? 4'b1111 : ~(4'b0001 << k);
      bus.seg       <= cur_seg;
      bus.dp        <= ~snap_dp[k];
    end
  end

endmodule
